ramoutput_write_arbiter: RTL and testbench

- Shares the dual-write-port GEMM output RAM (64 x 19-bit signed, two writes per cycle under one shared write_enable) between NUM_REQ result producers (PE rows).
- Arbitrates round-robin, grants up to two writes per cycle, and drives the RAM's write_enable/addr_1/addr_2/mdi_1/mdi_2 from registers.
- Counts committed writes per matrix and signals done when TOTAL_WRITES results are stored.

---
 rtl/ramoutput_write_arbiter_pkg.sv | 18 +
 rtl/ramoutput_write_arbiter_rr_pick2.sv | 54 +++++
 rtl/ramoutput_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_ramoutput_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ramoutput_write_arbiter_pkg.sv
// Shared types and GEMM output RAM geometry for the output write arbiter.
package ramoutput_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam int GEMM_ADDR_W    = 6;
  localparam int GEMM_ACC_W     = 19;
  localparam int GEMM_OUT_DEPTH = 64;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/ramoutput_write_arbiter_rr_pick2.sv
// Combinational round-robin picker: first valid requester from ptr_i, plus a
// second one whose address differs from the first (unless only one write remains).
module rr_pick2 #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [IDX_W-1:0]          ptr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  input  logic                      last_one_i,
  output logic [IDX_W-1:0]          g1_idx_o,
  output logic                      g1_vld_o,
  output logic [IDX_W-1:0]          g2_idx_o,
  output logic                      g2_vld_o
);

  logic [ADDR_W-1:0] addr_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = addr_i[i*ADDR_W +: ADDR_W];
  end

  logic [IDX_W:0]    sum;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] g1_addr;

  always_comb begin
    g1_idx_o = '0;
    g1_vld_o = 1'b0;
    g2_idx_o = '0;
    g2_vld_o = 1'b0;
    g1_addr  = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (valid_i[idx]) begin
        if (!g1_vld_o) begin
          g1_vld_o = 1'b1;
          g1_idx_o = idx;
          g1_addr  = addr_a[idx];
        end else if (!g2_vld_o && !last_one_i && (addr_a[idx] != g1_addr)) begin
          // same-address requester is passed over and simply retries later
          g2_vld_o = 1'b1;
          g2_idx_o = idx;
        end
      end
    end
  end

endmodule

// File: rtl/ramoutput_write_arbiter.sv
// Shares the dual-write-port GEMM output RAM between NUM_REQ producers,
// committing up to two writes per cycle and counting writes per matrix.
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | granting and committing writes
//   DONE  | TOTAL_WRITES stored, waiting for next start
module ramoutput_write_arbiter
  import ramoutput_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = GEMM_ADDR_W,
  parameter int DATA_W       = GEMM_ACC_W,
  parameter int TOTAL_WRITES = GEMM_OUT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      write_enable,
  output logic [ADDR_W-1:0]         addr_1,
  output logic [ADDR_W-1:0]         addr_2,
  output logic signed [DATA_W-1:0]  mdi_1,
  output logic signed [DATA_W-1:0]  mdi_2,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W:0]           write_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = ADDR_W + 1;

  arb_state_e               state_q;
  logic [IDX_W-1:0]         rr_ptr_q;
  logic [CNT_W-1:0]         count_q;
  logic                     we_q;
  logic [ADDR_W-1:0]        addr_1_q, addr_2_q;
  logic signed [DATA_W-1:0] mdi_1_q, mdi_2_q;
  logic                     busy_q, done_q;

  logic [ADDR_W-1:0]        addr_a [NUM_REQ];
  logic signed [DATA_W-1:0] data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  logic [NUM_REQ-1:0] pick_valid;
  logic               last_one;
  logic [IDX_W-1:0]   g1_idx, g2_idx, last_idx;
  logic               g1_vld, g2_vld;
  logic [CNT_W-1:0]   count_d;

  // grants only exist in RUN, which keeps req_ready low everywhere else
  assign pick_valid = (state_q == ST_RUN) ? req_valid : '0;
  assign last_one   = ((CNT_W'(TOTAL_WRITES) - count_q) == CNT_W'(1));

  rr_pick2 #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_pick (
    .valid_i    (pick_valid),
    .ptr_i      (rr_ptr_q),
    .addr_i     (req_addr),
    .last_one_i (last_one),
    .g1_idx_o   (g1_idx),
    .g1_vld_o   (g1_vld),
    .g2_idx_o   (g2_idx),
    .g2_vld_o   (g2_vld)
  );

  always_comb begin
    req_ready = '0;
    if (g1_vld) req_ready[g1_idx] = 1'b1;
    if (g2_vld) req_ready[g2_idx] = 1'b1;
  end

  assign last_idx = g2_vld ? g2_idx : g1_idx;
  assign count_d  = count_q + CNT_W'(g1_vld) + CNT_W'(g2_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      addr_1_q <= '0;
      addr_2_q <= '0;
      mdi_1_q  <= '0;
      mdi_2_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (g1_vld) begin
            we_q     <= 1'b1;
            addr_1_q <= addr_a[g1_idx];
            mdi_1_q  <= data_a[g1_idx];
            // single grant mirrors port 1 so the shared strobe writes one location
            addr_2_q <= g2_vld ? addr_a[g2_idx] : addr_a[g1_idx];
            mdi_2_q  <= g2_vld ? data_a[g2_idx] : data_a[g1_idx];
            count_q  <= count_d;
            rr_ptr_q <= IDX_W'(wrap_inc(int'(last_idx), NUM_REQ));
            if (count_d == CNT_W'(TOTAL_WRITES)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign write_enable = we_q;
  assign addr_1       = addr_1_q;
  assign addr_2       = addr_2_q;
  assign mdi_1        = mdi_1_q;
  assign mdi_2        = mdi_2_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign write_count  = count_q;

endmodule

// File: tb/tb_ramoutput_write_arbiter.sv
// Directed bench for ramoutput_write_arbiter with hand-computed expectations.
module tb_ramoutput_write_arbiter;

  logic              clk;
  logic              rst;
  logic              start;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [23:0]       req_addr;
  logic [75:0]       req_data;
  logic              write_enable;
  logic [5:0]        addr_1, addr_2;
  logic signed [18:0] mdi_1, mdi_2;
  logic              busy, done;
  logic [6:0]        write_count;

  logic [5:0]         a [4];
  logic signed [18:0] d [4];

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  int n_cmp = 0;
  int n_bad = 0;

  ramoutput_write_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .write_enable (write_enable),
    .addr_1       (addr_1),
    .addr_2       (addr_2),
    .mdi_1        (mdi_1),
    .mdi_2        (mdi_2),
    .busy         (busy),
    .done         (done),
    .write_count  (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    #2;
    chk("rst_we",    32'(write_enable), 32'(0));
    chk("rst_a1",    32'(addr_1),       32'(0));
    chk("rst_m2",    32'(mdi_2),        32'(0));
    chk("rst_busy",  32'(busy),         32'(0));
    chk("rst_done",  32'(done),         32'(0));
    chk("rst_cnt",   32'(write_count),  32'(0));
    tick();
    tick();
    rst = 1'b0;

    req_valid = 4'hF;
    #1 chk("idle_rdy", 32'(req_ready), 32'(0));
    req_valid = '0;

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", 32'(busy), 32'(1));
    chk("run_cnt",  32'(write_count), 32'(0));

    // two requesters, distinct addresses
    a[0] = 6'd3; d[0] = -19'sd5;
    a[2] = 6'd9; d[2] = 19'sd100;
    req_valid = 4'b0101;
    #1 chk("t1_rdy", 32'(req_ready), 32'(4'b0101));
    tick();
    req_valid = '0;
    chk("t1_we",  32'(write_enable), 32'(1));
    chk("t1_a1",  32'(addr_1),       32'(3));
    chk("t1_m1",  32'(mdi_1),        32'(-5));
    chk("t1_a2",  32'(addr_2),       32'(9));
    chk("t1_m2",  32'(mdi_2),        32'(100));
    chk("t1_cnt", 32'(write_count),  32'(2));

    // pointer now 3: scan 3,0,1,2
    for (int i = 0; i < 4; i++) begin
      a[i] = 6'(10 + i);
      d[i] = 19'(1000 + i);
    end
    req_valid = 4'hF;
    #1 chk("ptr_rdy", 32'(req_ready), 32'(4'b1001));
    tick();
    req_valid = '0;
    chk("ptr_a1",  32'(addr_1),      32'(13));
    chk("ptr_a2",  32'(addr_2),      32'(10));
    chk("ptr_cnt", 32'(write_count), 32'(4));

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_cnt",  32'(write_count),  32'(4));
    chk("ign_busy", 32'(busy),         32'(1));
    chk("ign_we",   32'(write_enable), 32'(0));

    // single requester duplicates port 1 onto port 2
    a[1] = 6'd7; d[1] = 19'sd42;
    req_valid = 4'b0010;
    #1 chk("t2_rdy", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    chk("t2_we",  32'(write_enable), 32'(1));
    chk("t2_a1",  32'(addr_1),       32'(7));
    chk("t2_a2",  32'(addr_2),       32'(7));
    chk("t2_m1",  32'(mdi_1),        32'(42));
    chk("t2_m2",  32'(mdi_2),        32'(42));
    chk("t2_cnt", 32'(write_count),  32'(5));

    tick();
    chk("hold_we", 32'(write_enable), 32'(0));
    chk("hold_a1", 32'(addr_1),       32'(7));
    chk("hold_m2", 32'(mdi_2),        32'(42));

    // bring pointer back to 0
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    chk("pre3_cnt", 32'(write_count), 32'(6));

    // address collision
    a[0] = 6'd5; d[0] = 19'sd11;
    a[1] = 6'd5; d[1] = 19'sd22;
    req_valid = 4'b0011;
    #1 chk("t3_rdy0", 32'(req_ready), 32'(4'b0001));
    tick();
    req_valid = 4'b0010;
    chk("t3_a1a", 32'(addr_1),      32'(5));
    chk("t3_m2a", 32'(mdi_2),       32'(11));
    chk("t3_cnta", 32'(write_count), 32'(7));
    #1 chk("t3_rdy1", 32'(req_ready), 32'(4'b0010));
    tick();
    req_valid = '0;
    chk("t3_a1b", 32'(addr_1),       32'(5));
    chk("t3_m1b", 32'(mdi_1),        32'(22));
    chk("t3_m2b", 32'(mdi_2),        32'(22));
    chk("t3_cntb", 32'(write_count), 32'(8));

    // reset with a grant pending (pointer is 2)
    a[0] = 6'd3; a[2] = 6'd9;
    req_valid = 4'b0101;
    #1 chk("t6_rdy", 32'(req_ready), 32'(4'b0101));
    rst = 1'b1;
    #1;
    chk("t6_we_async", 32'(write_enable), 32'(0));
    chk("t6_cnt_async", 32'(write_count), 32'(0));
    tick();
    chk("t6_we",   32'(write_enable), 32'(0));
    chk("t6_cnt",  32'(write_count),  32'(0));
    chk("t6_a1",   32'(addr_1),       32'(0));
    chk("t6_m1",   32'(mdi_1),        32'(0));
    chk("t6_busy", 32'(busy),         32'(0));
    chk("t6_done", 32'(done),         32'(0));
    chk("t6_rdy0", 32'(req_ready),    32'(0));
    rst = 1'b0;
    req_valid = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_restart_cnt",  32'(write_count), 32'(0));
    chk("t6_restart_busy", 32'(busy),        32'(1));

    // fairness: all valid, distinct addresses, pointer from 0
    for (int i = 0; i < 4; i++) begin
      a[i] = 6'(20 + i);
      d[i] = -19'(7 * (i + 1));
    end
    req_valid = 4'hF;
    for (int c = 0; c < 32; c++) begin
      #1 chk("t4_rdy", 32'(req_ready), (c % 2 == 0) ? 32'(4'b0011) : 32'(4'b1100));
      tick();
      chk("t4_cnt", 32'(write_count), 32'(2 * (c + 1)));
    end
    chk("t4_done", 32'(done),         32'(1));
    chk("t4_busy", 32'(busy),         32'(0));
    chk("t4_we",   32'(write_enable), 32'(1));
    chk("t4_a1",   32'(addr_1),       32'(22));
    chk("t4_a2",   32'(addr_2),       32'(23));
    chk("t4_m2",   32'(mdi_2),        32'(-28));
    chk("t4_rdy_done", 32'(req_ready), 32'(0));
    tick();
    chk("t4_we_after", 32'(write_enable), 32'(0));
    chk("t4_cnt_hold", 32'(write_count),  32'(64));
    req_valid = '0;

    // odd tail: restart from DONE, reach 63 then offer two requesters
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_cnt0", 32'(write_count), 32'(0));
    chk("t5_done0", 32'(done),       32'(0));
    req_valid = 4'b0001;
    tick();
    chk("t5_cnt1", 32'(write_count), 32'(1));
    req_valid = 4'hF;
    for (int k = 0; k < 31; k++) begin
      #1 chk("t5_rdy", 32'(req_ready), (k % 2 == 0) ? 32'(4'b0110) : 32'(4'b1001));
      tick();
    end
    chk("t5_cnt63", 32'(write_count), 32'(63));
    chk("t5_busy63", 32'(busy),       32'(1));
    req_valid = 4'b1001;
    #1 chk("t5_rdy_tail", 32'(req_ready), 32'(4'b1000));
    tick();
    req_valid = '0;
    chk("t5_cnt64", 32'(write_count), 32'(64));
    chk("t5_done",  32'(done),        32'(1));
    chk("t5_busy",  32'(busy),        32'(0));
    chk("t5_we",    32'(write_enable), 32'(1));
    chk("t5_a1",    32'(addr_1),      32'(23));
    chk("t5_a2",    32'(addr_2),      32'(23));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
